rect_fill_writer: RTL and testbench
===================================

# rect_fill_writer

Upstream drawing stage for the framebuffer write port. Accepts solid-rectangle draw commands over a valid/ready handshake, clips them to the 640x480 screen, and emits one 4-bit colour-index write per cycle on a write bus. The bus (`wr_en`/`wr_addr`/`wr_data`) connects to one of `framebuffer_master`'s write ports (`wr1_en`/`addr_wr1`/`data_wr1`). Optionally clears the whole buffer at each frame boundary, using `global_vsync`.

## Interface
- `H_RES`, 640, visible pixels per line
- `V_RES`, 480, visible lines
- `ADDR_W`, 19, framebuffer address width
- `CLEAR_COLOR`, 4'd0, colour index used by frame clear
- `clk`  in  1  pixel clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `vsync`  in  1  global vsync, synchronous to `clk`
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_x0`  in  10  left column
- `cmd_y0`  in  9  top row
- `cmd_w`  in  10  width in pixels
- `cmd_h`  in  9  height in lines
- `cmd_color`  in  4  colour index
- `wr_en`  out  1  write strobe
- `wr_addr`  out  ADDR_W  pixel address, `y*H_RES + x`
- `wr_data`  out  4  colour index
- `busy`  out  1  state is not IDLE
- `rect_done`  out  1  one-cycle pulse when a command finishes

## Operation
- States:
  - IDLE: command acceptance.
  - SETUP: one cycle; computes clipped bounds.
  - FILL: writes the rectangle.
  - CLEAR: present only with the macro; writes the whole buffer.
- `cmd_ready = (state==IDLE) && !clear_pending`. It is combinational from state and reads 1 after reset.
- Accept: `cmd_valid && cmd_ready` in IDLE. All command fields are latched and the block moves to SETUP. Inputs are don't-care afterwards.
- SETUP clipping, using 11-bit sums:
  - `x_end = min(x0+w, H_RES)`, `y_end = min(y0+h, V_RES)`.
  - The command is empty if `x0>=H_RES`, `y0>=V_RES`, `w==0` or `h==0`. An empty command goes SETUP→IDLE with `rect_done` and no writes.
  - Non-empty: row base is `y0*H_RES`, computed by shift-add (`y<<9 + y<<7` for 640); no general multiplier. Then go to FILL.
- FILL order and addressing:
  - Row-major: x from `x0` to `x_end-1`, then the next row.
  - `wr_addr` increments by 1 within a row. At row end, row base advances by H_RES.
  - `wr_en=1` every FILL cycle; no bubbles between rows.
- After the last pixel: go to IDLE and pulse `rect_done` in the first IDLE cycle.
- Reset mid-operation: immediate return to IDLE. All outputs drop to 0 asynchronously, the pending clear is discarded, and the partial rectangle is abandoned.
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `rect_done=0`, state IDLE.

## Timing
- Command accepted at edge N, SETUP in cycle N+1, first `wr_en` in cycle N+2.
- A clipped rectangle of W×H occupies exactly W·H consecutive write cycles. `rect_done` follows in the next cycle, and `cmd_ready` may be 1 in that same cycle.
- Back-to-back commands: minimum spacing is W·H + 2 cycles.
- `wr_addr`, `wr_data` and `wr_en` are registered outputs.
- The framebuffer write is taken on the same edge that sees `wr_en=1`.
- `rect_done` is registered and lasts exactly one cycle.

## Configuration
- Macro: `RECT_FRAME_CLEAR_EN`.
- Defined:
  - A vsync 0→1 edge, detected against a 1-cycle registered copy, sets `clear_pending`.
  - In IDLE with `clear_pending`, the block enters CLEAR and clears `clear_pending`. CLEAR writes `CLEAR_COLOR` to addresses 0..H_RES·V_RES-1 (307200 cycles), then returns to IDLE. CLEAR does not pulse `rect_done`.
  - An edge during SETUP or FILL is latched; the clear starts after the current rectangle. An edge during CLEAR is ignored.
  - If the clear is pending and a command is valid in the same IDLE cycle, the clear wins.
- Undefined:
  - `vsync` is unused, there is no CLEAR state, and `cmd_ready = (state==IDLE)`.

## Test plan
- **Basic fill.** Reset, then command x0=10, y0=2, w=3, h=2, color=5 → writes to 1290,1291,1292,1930,1931,1932 with data 5 in cycles N+2..N+7; `rect_done` in N+8.
- **Clipping.** Command x0=638, y0=479, w=5, h=4 → exactly 2 writes, to 307198 and 307199.
- **Empty commands.** w=0, then x0=700 → no `wr_en`; `rect_done` 2 cycles after each accept.
- **Reset mid-fill.** Command 100×100, then `reset` pulsed after 50 writes → `wr_en`, `busy` and `rect_done` go to 0 immediately; next command executes normally.
- **Frame clear (macro on).** Vsync rises during a 4×4 fill → the fill's 16 writes complete, then 307200 writes of CLEAR_COLOR with `cmd_ready=0`, addresses 0..307199.
- **Back-to-back.** Two commands with `cmd_valid` held → second accepted in the `rect_done` cycle of the first; writes resume 2 cycles later.

Source files
------------

// File: rtl/rect_fill_writer.sv
// -----------------------------------------------------------------------------
// rect_fill_writer
//
// Drawing stage that feeds one framebuffer write port. It accepts
// solid-rectangle draw commands over a valid/ready handshake, clips each one
// to the H_RES x V_RES screen, and emits one 4-bit colour-index write per
// clock in row-major order.
//
// Optional feature (compile-time macro RECT_FRAME_CLEAR_EN):
//   A rising edge on vsync schedules a full-buffer clear with CLEAR_COLOR.
//   The clear starts once the block is back in IDLE and takes priority over
//   a waiting command. Without the macro, vsync is ignored.
//
// Parameters:
//   H_RES, V_RES  visible screen size (the row-base shift-add assumes 640)
//   ADDR_W        framebuffer address width
//   CLEAR_COLOR   colour index written by the frame clear
//
// Ports:
//   clk           pixel clock, all logic on the rising edge
//   reset         asynchronous, active-high reset
//   vsync         frame sync, synchronous to clk (used only with the macro)
//   cmd_valid     command present
//   cmd_ready     block can accept a command (combinational from state)
//   cmd_x0/cmd_y0 top-left corner of the rectangle
//   cmd_w/cmd_h   rectangle size in pixels/lines
//   cmd_color     colour index to fill with
//   wr_en         registered write strobe
//   wr_addr       registered pixel address, y*H_RES + x
//   wr_data       registered colour index
//   busy          state is not IDLE
//   rect_done     registered one-cycle pulse when a command finishes
// -----------------------------------------------------------------------------
module rect_fill_writer #(
    parameter int         H_RES       = 640,
    parameter int         V_RES       = 480,
    parameter int         ADDR_W      = 19,
    parameter logic [3:0] CLEAR_COLOR = 4'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x0,
    input  logic [8:0]        cmd_y0,
    input  logic [9:0]        cmd_w,
    input  logic [8:0]        cmd_h,
    input  logic [3:0]        cmd_color,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              rect_done
);

    localparam logic [10:0]       H_RES_C   = 11'(H_RES);
    localparam logic [10:0]       V_RES_C   = 11'(V_RES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_RES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_FILL  = 2'd2
`ifdef RECT_FRAME_CLEAR_EN
        ,
        S_CLEAR = 2'd3
`endif
    } state_t;

    state_t state;
    state_t state_next;

    // Latched command fields; the command inputs are don't-care after accept.
    logic [9:0]        x0_q;
    logic [8:0]        y0_q;
    logic [9:0]        w_q;
    logic [8:0]        h_q;
    logic [3:0]        color_q;

    // Clipped bounds (exclusive) and the fill walk position.
    logic [10:0]       x_end_q;
    logic [10:0]       y_end_q;
    logic [9:0]        cur_x;
    logic [8:0]        cur_y;
    logic [ADDR_W-1:0] row_base_q;

    logic [10:0]       x_sum;
    logic [10:0]       y_sum;
    logic [10:0]       x_end;
    logic [10:0]       y_end;
    logic              rect_empty;
    logic [ADDR_W-1:0] row_base;
    logic              row_last;
    logic              rect_last;
    logic              accept;

    // -------------------------------------------------------------------------
    // Optional frame clear
    // -------------------------------------------------------------------------
`ifdef RECT_FRAME_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    logic vsync_q;
    logic clear_pending;
    logic vsync_rise;
    logic start_clear;
    logic clear_last;

    assign vsync_rise  = vsync && !vsync_q;
    assign start_clear = (state == S_IDLE) && clear_pending;
    assign clear_last  = (wr_addr == LAST_ADDR);
    assign cmd_ready   = (state == S_IDLE) && !clear_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q       <= 1'b0;
            clear_pending <= 1'b0;
        end else begin
            vsync_q <= vsync;
            // Taking the pending clear wins over a coincident edge; an edge
            // seen while already clearing is dropped.
            if (start_clear) begin
                clear_pending <= 1'b0;
            end else if (vsync_rise && (state != S_CLEAR)) begin
                clear_pending <= 1'b1;
            end
        end
    end
`else
    logic [4:0] unused_ok;
    assign unused_ok = {vsync, CLEAR_COLOR};
    assign cmd_ready = (state == S_IDLE);
`endif

    // -------------------------------------------------------------------------
    // Clipping and walk arithmetic
    // -------------------------------------------------------------------------
    assign x_sum = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum = {2'b0, y0_q} + {2'b0, h_q};
    assign x_end = (x_sum > H_RES_C) ? H_RES_C : x_sum;
    assign y_end = (y_sum > V_RES_C) ? V_RES_C : y_sum;

    assign rect_empty = ({1'b0, x0_q} >= H_RES_C) || ({2'b0, y0_q} >= V_RES_C) ||
                        (w_q == 10'd0) || (h_q == 9'd0);

    // y*640 as y*512 + y*128, avoiding a general multiplier.
    assign row_base = (ADDR_W'(y0_q) << 9) + (ADDR_W'(y0_q) << 7);

    assign row_last  = (({1'b0, cur_x} + 11'd1) == x_end_q);
    assign rect_last = row_last && (({2'b0, cur_y} + 11'd1) == y_end_q);

    assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;
    assign busy   = (state != S_IDLE);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default before the
    // case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
`ifdef RECT_FRAME_CLEAR_EN
                if (start_clear) begin
                    state_next = S_CLEAR;
                end else
`endif
                if (accept) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: state_next = rect_empty ? S_IDLE : S_FILL;
            S_FILL: begin
                if (rect_last) begin
                    state_next = S_IDLE;
                end
            end
`ifdef RECT_FRAME_CLEAR_EN
            S_CLEAR: begin
                if (clear_last) begin
                    state_next = S_IDLE;
                end
            end
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 4'd0;
            rect_done  <= 1'b0;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            row_base_q <= '0;
        end else begin
            rect_done <= 1'b0;
            case (state)
                S_IDLE: begin
`ifdef RECT_FRAME_CLEAR_EN
                    if (start_clear) begin
                        wr_en   <= 1'b1;
                        wr_addr <= '0;
                        wr_data <= CLEAR_COLOR;
                    end else
`endif
                    if (accept) begin
                        x0_q    <= cmd_x0;
                        y0_q    <= cmd_y0;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                    end
                end
                S_SETUP: begin
                    x_end_q <= x_end;
                    y_end_q <= y_end;
                    if (rect_empty) begin
                        rect_done <= 1'b1;
                    end else begin
                        wr_en      <= 1'b1;
                        wr_addr    <= row_base + ADDR_W'(x0_q);
                        wr_data    <= color_q;
                        cur_x      <= x0_q;
                        cur_y      <= y0_q;
                        row_base_q <= row_base;
                    end
                end
                S_FILL: begin
                    if (rect_last) begin
                        wr_en     <= 1'b0;
                        rect_done <= 1'b1;
                    end else if (row_last) begin
                        // Wrap to the next row with no bubble cycle.
                        cur_x      <= x0_q;
                        cur_y      <= cur_y + 9'd1;
                        row_base_q <= row_base_q + LINE_STEP;
                        wr_addr    <= row_base_q + LINE_STEP + ADDR_W'(x0_q);
                    end else begin
                        cur_x   <= cur_x + 10'd1;
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
`ifdef RECT_FRAME_CLEAR_EN
                S_CLEAR: begin
                    if (clear_last) begin
                        wr_en <= 1'b0;
                    end else begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_writer.sv
// -----------------------------------------------------------------------------
// tb_rect_fill_writer
//
// Directed plus randomized bench for rect_fill_writer. Expected write
// sequences come from a simple clip-and-enumerate model: every (x, y) inside
// the command rectangle and the screen yields address y*640 + x, row-major.
// Outputs are sampled on the falling edge; inputs change there as well.
// -----------------------------------------------------------------------------
module tb_rect_fill_writer;

    localparam int H = 640;
    localparam int V = 480;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0;
    logic [8:0]  cmd_y0;
    logic [9:0]  cmd_w;
    logic [8:0]  cmd_h;
    logic [3:0]  cmd_color;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [3:0]  wr_data;
    logic        busy;
    logic        rect_done;

    int total = 0;
    int bad   = 0;

    rect_fill_writer dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .rect_done (rect_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present a command while IDLE; it is accepted at the next rising edge.
    task automatic issue(input int x0, input int y0, input int w, input int h, input int c);
        @(negedge clk);
        check("ready_before_accept", cmd_ready, 1);
        cmd_x0    = 10'(x0);
        cmd_y0    = 9'(y0);
        cmd_w     = 10'(w);
        cmd_h     = 9'(h);
        cmd_color = 4'(c);
        cmd_valid = 1'b1;
    endtask

    // The cycle after acceptance: SETUP, no write yet.
    task automatic setup_cycle(input bit hold_valid);
        @(negedge clk);
        if (!hold_valid) cmd_valid = 1'b0;
        check("setup_busy", busy, 1);
        check("setup_wr_en", wr_en, 0);
        check("setup_ready", cmd_ready, 0);
        check("setup_done", rect_done, 0);
    endtask

    // Reference model: enumerate the clipped rectangle, then expect one write
    // per cycle followed by a single rect_done cycle.
    task automatic expect_body(input int x0, input int y0, input int w, input int h,
                               input int c, input bit ready_after);
        int q[$];
        int xe = x0 + w;
        int ye = y0 + h;
        if (xe > H) xe = H;
        if (ye > V) ye = V;
        for (int y = y0; y < ye; y++)
            for (int x = x0; x < xe; x++)
                q.push_back(y * H + x);
        foreach (q[i]) begin
            @(negedge clk);
            check("fill_wr_en", wr_en, 1);
            check("fill_addr", wr_addr, q[i]);
            check("fill_data", wr_data, c);
            check("fill_no_done", rect_done, 0);
        end
        @(negedge clk);
        check("done_pulse", rect_done, 1);
        check("done_wr_en", wr_en, 0);
        check("done_ready", cmd_ready, ready_after);
    endtask

    task automatic quiet_cycle();
        @(negedge clk);
        check("quiet_done", rect_done, 0);
        check("quiet_wr_en", wr_en, 0);
        check("quiet_busy", busy, 0);
    endtask

    task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int c);
        issue(x0, y0, w, h, c);
        setup_cycle(1'b0);
        expect_body(x0, y0, w, h, c, 1'b1);
        quiet_cycle();
    endtask

    initial begin
        int x0, y0, w, h, c;

        reset     = 1'b1;
        vsync     = 1'b0;
        cmd_valid = 1'b0;
        cmd_x0    = '0;
        cmd_y0    = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;

        // Reset state
        #12;
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", rect_done, 0);
        check("rst_ready", cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;

        // Basic fill: 1290..1292, 1930..1932 with colour 5
        run_cmd(10, 2, 3, 2, 5);

        // Clipping at the bottom-right corner: 307198, 307199
        run_cmd(638, 479, 5, 4, 11);

        // Empty commands: zero width, then off-screen x
        run_cmd(20, 20, 0, 5, 3);
        run_cmd(700, 10, 8, 2, 3);
        run_cmd(30, 479, 2, 0, 6);

        // Reset mid-fill after 50 writes
        issue(5, 7, 100, 100, 9);
        setup_cycle(1'b0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("pre_reset_addr", wr_addr, 7 * H + 5 + i);
            check("pre_reset_wr_en", wr_en, 1);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_wr_en", wr_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", rect_done, 0);
        check("mid_rst_addr", wr_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        run_cmd(1, 1, 4, 3, 12);

        // Back-to-back: second command waits on a held cmd_valid
        issue(50, 60, 3, 2, 7);
        setup_cycle(1'b1);
        cmd_x0    = 10'd200;
        cmd_y0    = 9'd100;
        cmd_w     = 10'd2;
        cmd_h     = 9'd2;
        cmd_color = 4'd14;
        expect_body(50, 60, 3, 2, 7, 1'b1);
        setup_cycle(1'b0);
        expect_body(200, 100, 2, 2, 14, 1'b1);
        quiet_cycle();

        // Randomized commands, biased towards the screen edges for clipping
        for (int n = 0; n < 20; n++) begin
            if (n % 3 == 0) begin
                x0 = H - int'($urandom_range(0, 8));
                y0 = V - int'($urandom_range(0, 5));
            end else begin
                x0 = int'($urandom_range(0, 700));
                y0 = int'($urandom_range(0, 500));
            end
            w = int'($urandom_range(0, 12));
            h = int'($urandom_range(0, 6));
            c = int'($urandom_range(0, 15));
            run_cmd(x0, y0, w, h, c);
        end

`ifdef RECT_FRAME_CLEAR_EN
        // Frame clear: vsync rises during a 4x4 fill
        issue(0, 0, 4, 4, 3);
        setup_cycle(1'b0);
        vsync = 1'b1;
        expect_body(0, 0, 4, 4, 3, 1'b0);
        vsync = 1'b0;
        for (int a = 0; a < H * V; a++) begin
            @(negedge clk);
            check("clear_word", {cmd_ready, wr_en, wr_data, wr_addr},
                  {1'b0, 1'b1, 4'd0, 19'(a)});
        end
        @(negedge clk);
        check("clear_end_wr_en", wr_en, 0);
        check("clear_end_done", rect_done, 0);
        check("clear_end_ready", cmd_ready, 1);
        run_cmd(3, 3, 2, 2, 8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
